spcpu_mem_responder: RTL
========================

// Module: spcpu_mem_responder
//
// PURPOSE
// Synthesizable memory-side responder for the spcpu data bus (data_inout,
// data_inout_addr, data_acc_sz, data_inout_we). It holds a single-port RAM of
// 16-bit halfwords and serves 8-bit and 16-bit reads and writes issued by
// spcpu. It drives the shared tristate bus during reads. It replaces the
// bench-only memory, so spcpu can run on one clock.
//
// PARAMETERS
// ADDR_WIDTH     16    width of data_inout_addr (byte address)
// MEM_ADDR_BITS  10    log2 of RAM depth in halfwords (default 1024 x 16b)
// DATA_WIDTH     16    width of data_inout; fixed at 16
//
// PORTS
// clk              in     1           system clock, rising edge
// reset            in     1           asynchronous, active-high
// data_inout       inout  DATA_WIDTH  shared data bus; driven only on reads
// data_inout_addr  in     ADDR_WIDTH  byte address from spcpu
// data_acc_sz      in     1           0 = 8-bit access, 1 = 16-bit
//                                     (pkg_cpu::cpu_data_acc_sz_16 == 1)
// data_inout_we    in     1           1 = spcpu writes, 0 = spcpu reads
// mem_ready        out    1           1 = RAM clear finished, bus serviced
// bad_access       out    1           1-cycle pulse on misaligned 16-bit access
//
// BEHAVIOUR
// Clock and reset: one clock, clk. reset is asynchronous and active-high.
// Reset values:
//  - mem_ready = 0, bad_access = 0, rd_data_q = 0
//  - clear counter = 0, FSM = ST_CLEAR
// FSM:
//  - ST_CLEAR: write 0 to RAM[clr_cnt] each cycle and increment clr_cnt.
//    At clr_cnt == 2**MEM_ADDR_BITS-1, write it, go to ST_READY, set
//    mem_ready = 1 on the next cycle.
//  - In ST_CLEAR, bus writes are ignored and rd_data_q stays 0.
//  - ST_READY: service the bus every cycle. The FSM leaves ST_READY only on
//    reset. Reset mid-clear or mid-access restarts ST_CLEAR at 0.
// Address mapping:
//  - Halfword index = data_inout_addr[MEM_ADDR_BITS:1]. Upper bits are
//    ignored, so addresses wrap modulo 2**(MEM_ADDR_BITS+1) bytes.
//  - Big-endian: even byte address = bits [15:8], odd = bits [7:0].
// Write (posedge, data_inout_we == 1, ST_READY):
//  - 16-bit: RAM[idx] <= data_inout.
//  - 8-bit: data_inout[7:0] goes into the lane selected by addr[0]. The
//    other byte is preserved.
// Read (posedge, data_inout_we == 0):
//  - rd_data_q <= RAM[idx], with write-first forwarding (not needed with a
//    single port, but a write then read of the same address must return the
//    new data).
//  - 8-bit: rd_data_q = {8'h00, selected byte}.
//  - Latency: the address presented before edge N gives data valid from
//    after edge N until edge N+1, where spcpu samples it.
// Bus drive:
//  - data_inout = data_inout_we ? 16'hz : rd_data_q, combinational on we.
//  - This never drives while spcpu drives.
// Misaligned access:
//  - data_acc_sz == 1 with addr[0] == 1 is treated as addr & ~1.
//  - bad_access = 1 for the cycle after the sampling edge. The access still
//    completes.
// No write occurs when the FSM is not in ST_READY, regardless of we.
//
// TESTING
// 1. Assert reset for 2 cycles, then release -> mem_ready rises exactly
//    2**MEM_ADDR_BITS+1 cycles later. A 16-bit read of any address returns
//    16'h0000.
// 2. 16-bit write 16'hBEEF to 0x0010, then 16-bit read of 0x0010 ->
//    data_inout = 16'hBEEF one cycle after the read edge.
// 3. 8-bit write 8'h12 to 0x0011 over BEEF, then 16-bit read -> 16'hBE12.
//    8-bit read of 0x0010 -> 16'h00BE.
// 4. 16-bit write 16'hA5A5 to 0x0013 (misaligned) -> bad_access pulses one
//    cycle. A read of 0x0012 returns 16'hA5A5.
// 5. Write 16'h1234 to 0x0000, then read 0x0800 (MEM_ADDR_BITS = 10) ->
//    16'h1234 (wrap). While we = 1, data_inout is driven only by the bench
//    (no X from contention).
// 6. Assert reset mid-clear and after writes -> mem_ready drops at once and
//    the full clear reruns. A read of 0x0010 returns 16'h0000 afterwards.

Source files
------------

// File: rtl/spcpu_mem_responder.sv
// spcpu data-bus memory responder: 16-bit halfword RAM, byte/halfword access,
// big-endian lanes, tristate read drive, zero-fill after reset.
module spcpu_mem_responder #(
    parameter int ADDR_WIDTH    = 16,
    parameter int MEM_ADDR_BITS = 10,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire  [DATA_WIDTH-1:0] data_inout,
    input  logic [ADDR_WIDTH-1:0] data_inout_addr,
    input  logic                  data_acc_sz,
    input  logic                  data_inout_we,
    output logic                  mem_ready,
    output logic                  bad_access
);

    localparam int DEPTH = 2 ** MEM_ADDR_BITS;
    localparam logic [MEM_ADDR_BITS-1:0] CNT_ONE  = 1;
    localparam logic [MEM_ADDR_BITS-1:0] CNT_LAST = {MEM_ADDR_BITS{1'b1}};

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                   state;
    logic [MEM_ADDR_BITS-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0]    rd_data_q;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic [MEM_ADDR_BITS-1:0] idx;
    logic                     lane_lo;
    logic [DATA_WIDTH-1:0]    cur;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic                     wr_en;
    logic [MEM_ADDR_BITS-1:0] wr_idx;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     unused_addr_bits;

    // Bit 0 is the byte lane; bits above the RAM span wrap away.
    assign idx     = data_inout_addr[MEM_ADDR_BITS:1];
    assign lane_lo = data_inout_addr[0];
    assign cur     = mem[idx];

    assign unused_addr_bits = &{1'b0, data_inout_addr[ADDR_WIDTH-1:MEM_ADDR_BITS+1]};

    assign data_inout = data_inout_we ? {DATA_WIDTH{1'bz}} : rd_data_q;

    always_comb begin
        rd_word = cur;
        if (!data_acc_sz) begin
            rd_word = {8'h00, lane_lo ? cur[7:0] : cur[15:8]};
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = clr_cnt;
        wr_data = '0;
        unique case (1'b1)
            state == ST_CLEAR: begin
                wr_en = 1'b1;
            end
            state == ST_READY && data_inout_we: begin
                wr_en  = 1'b1;
                wr_idx = idx;
                if (data_acc_sz) begin
                    wr_data = data_inout;
                end else if (lane_lo) begin
                    wr_data = {cur[15:8], data_inout[7:0]};
                end else begin
                    wr_data = {data_inout[7:0], cur[7:0]};
                end
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            mem_ready  <= 1'b0;
            bad_access <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    mem_ready  <= 1'b0;
                    bad_access <= 1'b0;
                    clr_cnt    <= clr_cnt + CNT_ONE;
                    if (clr_cnt == CNT_LAST) begin
                        state <= ST_READY;
                    end
                end
                ST_READY: begin
                    mem_ready  <= 1'b1;
                    bad_access <= data_acc_sz & lane_lo;
                    if (!data_inout_we) begin
                        rd_data_q <= rd_word;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule
